// File: rtl/reg_transfer_ctrl_if.sv
// rtl/reg_transfer_ctrl_if.sv - command handshake channel into the register-transfer sequencer
interface reg_transfer_ctrl_if #(
  parameter int REG_WIDTH = 12
) ();
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [1:0]           cmd_op;
  logic [3:0]           cmd_src;
  logic [3:0]           cmd_dst;
  logic [REG_WIDTH-1:0] cmd_imm;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_src,
    output cmd_dst,
    output cmd_imm,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_src,
    input  cmd_dst,
    input  cmd_imm,
    output cmd_ready
  );
endinterface

// File: rtl/reg_transfer_ctrl.sv
// rtl/reg_transfer_ctrl.sv - queued MOV/LDI/INC/RD sequencer driving one-hot register-file reads and writes
module reg_transfer_ctrl #(
  parameter int REG_COUNT  = 11,
  parameter int REG_WIDTH  = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  reg_transfer_ctrl_if.slave   cmd,
  output logic [REG_COUNT-1:0] read_en,
  output logic [REG_COUNT-1:0] write_en,
  output logic [REG_WIDTH-1:0] rf_datain,
  input  logic [REG_WIDTH-1:0] rf_dataout,
  output logic                 result_valid,
  output logic [REG_WIDTH-1:0] result_data,
  output logic                 cmd_err,
  output logic                 busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);
  localparam logic [4:0]       REG_LIMIT = 5'(REG_COUNT);

  localparam logic [1:0] OP_MOV = 2'b00;
  localparam logic [1:0] OP_LDI = 2'b01;
  localparam logic [1:0] OP_INC = 2'b10;
  localparam logic [1:0] OP_RD  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_READ   = 2'd1,
    S_WRITE  = 2'd2,
    S_RESULT = 2'd3
  } state_t;

  typedef struct packed {
    logic [1:0]           op;
    logic [3:0]           src;
    logic [3:0]           dst;
    logic [REG_WIDTH-1:0] imm;
  } cmd_t;

  cmd_t             fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_d;
  cmd_t             in_cmd;
  cmd_t             head;
  logic             push;
  logic             pop;
  logic             head_bad;

  state_t           state;
  state_t           next_state;
  logic [1:0]       cur_op;
  logic [3:0]       cur_dst;

  logic [REG_COUNT-1:0] read_en_d;
  logic [REG_COUNT-1:0] write_en_d;
  logic [REG_WIDTH-1:0] rf_datain_d;
  logic [REG_WIDTH-1:0] result_data_d;
  logic                 result_valid_d;
  logic                 cmd_err_d;
  logic                 busy_d;

  function automatic logic [REG_COUNT-1:0] onehot(input logic [3:0] idx);
    logic [REG_COUNT-1:0] sel;
    sel = '0;
    for (int i = 0; i < REG_COUNT; i++) begin
      if (idx == 4'(i)) sel[i] = 1'b1;
    end
    return sel;
  endfunction

  // No pop-bypass: ready is a pure function of the registered occupancy.
  assign cmd.cmd_ready = (count != FULL_CNT);
  assign push          = cmd.cmd_valid && cmd.cmd_ready;
  assign in_cmd        = {cmd.cmd_op, cmd.cmd_src, cmd.cmd_dst, cmd.cmd_imm};
  assign head          = fifo_mem[rd_ptr];

  always_comb begin
    logic src_bad;
    logic dst_bad;
    src_bad = ({1'b0, head.src} >= REG_LIMIT);
    dst_bad = ({1'b0, head.dst} >= REG_LIMIT);
    case (head.op)
      OP_MOV:  head_bad = src_bad || dst_bad;
      OP_RD:   head_bad = src_bad;
      default: head_bad = dst_bad;
    endcase
  end

  always_comb begin
    case ({push, pop})
      2'b10:   count_d = count + CNT_W'(1);
      2'b01:   count_d = count - CNT_W'(1);
      default: count_d = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= in_cmd;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_d;
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      cur_op  <= OP_MOV;
      cur_dst <= '0;
    end else begin
      state <= next_state;
      if (pop) begin
        cur_op  <= head.op;
        cur_dst <= head.dst;
      end
    end
  end

  // Next-state logic: pops happen in every state except READ.
  always_comb begin
    next_state = state;
    pop        = 1'b0;
    case (state)
      S_READ: begin
        next_state = (cur_op == OP_RD) ? S_RESULT : S_WRITE;
      end
      default: begin
        if (count != '0) begin
          pop = 1'b1;
          if (head_bad)              next_state = S_IDLE;
          else if (head.op == OP_LDI) next_state = S_WRITE;
          else                       next_state = S_READ;
        end else begin
          next_state = S_IDLE;
        end
      end
    endcase
  end

  // Output logic: values for the cycle about to begin, registered below.
  always_comb begin
    read_en_d      = '0;
    write_en_d     = '0;
    rf_datain_d    = '0;
    result_valid_d = 1'b0;
    result_data_d  = result_data;
    cmd_err_d      = pop && head_bad;
    case (next_state)
      S_READ: begin
        read_en_d = onehot((head.op == OP_INC) ? head.dst : head.src);
      end
      S_WRITE: begin
        if (state == S_READ) begin
          write_en_d  = onehot(cur_dst);
          rf_datain_d = (cur_op == OP_INC) ? rf_dataout + REG_WIDTH'(1) : rf_dataout;
        end else begin
          write_en_d  = onehot(head.dst);
          rf_datain_d = head.imm;
        end
      end
      S_RESULT: result_valid_d = 1'b1;
      default: ;
    endcase
    if (state == S_READ && cur_op == OP_RD) result_data_d = rf_dataout;
    busy_d = (next_state != S_IDLE) || (count_d != '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      read_en      <= '0;
      write_en     <= '0;
      rf_datain    <= '0;
      result_valid <= 1'b0;
      result_data  <= '0;
      cmd_err      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      read_en      <= read_en_d;
      write_en     <= write_en_d;
      rf_datain    <= rf_datain_d;
      result_valid <= result_valid_d;
      result_data  <= result_data_d;
      cmd_err      <= cmd_err_d;
      busy         <= busy_d;
    end
  end

endmodule

// File: tb/tb_reg_transfer_ctrl.sv
// tb/tb_reg_transfer_ctrl.sv - directed self-checking bench for reg_transfer_ctrl with a behavioural register file
module tb_reg_transfer_ctrl;
  localparam int RC = 11;
  localparam int RW = 12;
  localparam logic [1:0] OP_MOV = 2'b00;
  localparam logic [1:0] OP_LDI = 2'b01;
  localparam logic [1:0] OP_INC = 2'b10;
  localparam logic [1:0] OP_RD  = 2'b11;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [RC-1:0] read_en;
  logic [RC-1:0] write_en;
  logic [RW-1:0] rf_datain;
  logic [RW-1:0] rf_dataout;
  logic          result_valid;
  logic [RW-1:0] result_data;
  logic          cmd_err;
  logic          busy;

  reg_transfer_ctrl_if #(.REG_WIDTH(RW)) cmd_if ();

  reg_transfer_ctrl #(.REG_COUNT(RC), .REG_WIDTH(RW), .FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd          (cmd_if),
    .read_en      (read_en),
    .write_en     (write_en),
    .rf_datain    (rf_datain),
    .rf_dataout   (rf_dataout),
    .result_valid (result_valid),
    .result_data  (result_data),
    .cmd_err      (cmd_err),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Behavioural register file: write on the clock edge, combinational read.
  logic [RW-1:0] rf [RC];
  always @(posedge clk) begin
    for (int i = 0; i < RC; i++) begin
      if (reset) rf[i] <= '0;
      else if (write_en[i]) rf[i] <= rf_datain;
    end
  end
  always_comb begin
    rf_dataout = '0;
    for (int i = 0; i < RC; i++) if (read_en[i]) rf_dataout = rf[i];
  end

  logic [RC-1:0] wlog_en[$];
  logic [RW-1:0] wlog_data[$];
  logic [RW-1:0] rlog[$];
  int            overlap = 0;
  always @(negedge clk) begin
    if (write_en != '0) begin
      wlog_en.push_back(write_en);
      wlog_data.push_back(rf_datain);
    end
    if (result_valid) rlog.push_back(result_data);
    if (read_en != '0 && write_en != '0) overlap++;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [3:0] src, input logic [3:0] dst,
                      input logic [RW-1:0] imm);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = op;
    cmd_if.cmd_src   = src;
    cmd_if.cmd_dst   = dst;
    cmd_if.cmd_imm   = imm;
    step();
    cmd_if.cmd_valid = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_ready"},    32'(cmd_if.cmd_ready), 32'd1);
    check({tag, "_busy"},     32'(busy), 32'd0);
    check({tag, "_read_en"},  32'(read_en), 32'd0);
    check({tag, "_write_en"}, 32'(write_en), 32'd0);
    check({tag, "_datain"},   32'(rf_datain), 32'd0);
    check({tag, "_rvalid"},   32'(result_valid), 32'd0);
    check({tag, "_rdata"},    32'(result_data), 32'd0);
    check({tag, "_err"},      32'(cmd_err), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic accepted;
    logic rdy;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = '0;
    cmd_if.cmd_src   = '0;
    cmd_if.cmd_dst   = '0;
    cmd_if.cmd_imm   = '0;
    step();
    step();
    check_quiet("reset");
    reset = 1'b0;
    step();

    // Reset in the middle of an LDI write must drop write_en at once.
    send(OP_LDI, 4'd0, 4'd3, 12'h5A5);
    step();
    check("rst_mid_write_en", 32'(write_en), 32'h008);
    check("rst_mid_busy", 32'(busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("rst_async_write_en", 32'(write_en), 32'd0);
    step();
    step();
    reset = 1'b0;
    step();
    check_quiet("post_reset");

    // LDI r9, then RD r9
    send(OP_LDI, 4'd0, 4'd9, 12'h123);
    step();
    check("ldi9_write_en", 32'(write_en), 32'h200);
    check("ldi9_datain", 32'(rf_datain), 32'h123);
    step();
    check("ldi9_one_cycle", 32'(write_en), 32'd0);
    send(OP_RD, 4'd9, 4'd0, 12'h0);
    step();
    check("rd9_read_en", 32'(read_en), 32'h200);
    step();
    check("rd9_rvalid", 32'(result_valid), 32'd1);
    check("rd9_rdata", 32'(result_data), 32'h123);
    step();
    check("rd9_rvalid_pulse", 32'(result_valid), 32'd0);
    step();
    check("rd9_idle_busy", 32'(busy), 32'd0);

    // LDI r0=FFF, INC r0 (wraps), RD r0
    send(OP_LDI, 4'd0, 4'd0, 12'hFFF);
    send(OP_INC, 4'd0, 4'd0, 12'h0);
    send(OP_RD, 4'd0, 4'd0, 12'h0);
    check("inc_read_en", 32'(read_en), 32'h001);
    step();
    check("inc_write_en", 32'(write_en), 32'h001);
    check("inc_wrap_datain", 32'(rf_datain), 32'h000);
    step();
    check("inc_rd_read_en", 32'(read_en), 32'h001);
    step();
    check("inc_rd_rvalid", 32'(result_valid), 32'd1);
    check("inc_rd_rdata", 32'(result_data), 32'h000);
    step();

    // LDI r4=0AB, MOV r10<-r4, RD r10
    send(OP_LDI, 4'd0, 4'd4, 12'h0AB);
    send(OP_MOV, 4'd4, 4'd10, 12'h0);
    send(OP_RD, 4'd10, 4'd0, 12'h0);
    check("mov_read_en", 32'(read_en), 32'h010);
    step();
    check("mov_write_en", 32'(write_en), 32'h400);
    check("mov_datain", 32'(rf_datain), 32'h0AB);
    step();
    check("mov_rd_read_en", 32'(read_en), 32'h400);
    step();
    check("mov_rd_rvalid", 32'(result_valid), 32'd1);
    check("mov_rd_rdata", 32'(result_data), 32'h0AB);
    step();
    step();

    // 3 RDs stall the queue while 6 LDIs are offered with cmd_valid held high
    wlog_en.delete();
    wlog_data.delete();
    rlog.delete();
    for (int k = 0; k < 9; k++) begin
      cmd_if.cmd_valid = 1'b1;
      if (k < 3) begin
        cmd_if.cmd_op  = OP_RD;
        cmd_if.cmd_src = 4'd9;
        cmd_if.cmd_dst = 4'd0;
        cmd_if.cmd_imm = '0;
      end else begin
        cmd_if.cmd_op  = OP_LDI;
        cmd_if.cmd_src = 4'd0;
        cmd_if.cmd_dst = 4'(k - 2);
        cmd_if.cmd_imm = 12'h100 + 12'(k - 2);
      end
      accepted = 1'b0;
      for (int w = 0; w < 20 && !accepted; w++) begin
        rdy = cmd_if.cmd_ready;
        step();
        if (rdy) accepted = 1'b1;
      end
      check("fill_accept", 32'(accepted), 32'd1);
      if (k == 5) check("fill_ready_after_3rd", 32'(cmd_if.cmd_ready), 32'd1);
      if (k == 6) check("fill_ready_after_4th", 32'(cmd_if.cmd_ready), 32'd0);
    end
    cmd_if.cmd_valid = 1'b0;
    for (int w = 0; w < 12; w++) step();
    check("fill_drained_busy", 32'(busy), 32'd0);
    check("fill_write_count", 32'(wlog_en.size()), 32'd6);
    for (int i = 0; i < 6 && i < wlog_en.size(); i++) begin
      check($sformatf("fill_wr%0d_en", i), 32'(wlog_en[i]), 32'd1 << (i + 1));
      check($sformatf("fill_wr%0d_data", i), 32'(wlog_data[i]), 32'h101 + 32'(i));
    end
    check("fill_result_count", 32'(rlog.size()), 32'd3);
    for (int i = 0; i < 3 && i < rlog.size(); i++)
      check($sformatf("fill_rd%0d", i), 32'(rlog[i]), 32'h123);

    // Out-of-range source is discarded; the following LDI still runs
    wlog_en.delete();
    wlog_data.delete();
    send(OP_MOV, 4'd11, 4'd2, 12'h0);
    send(OP_LDI, 4'd0, 4'd2, 12'h0C3);
    check("bad_err", 32'(cmd_err), 32'd1);
    check("bad_read_en", 32'(read_en), 32'd0);
    check("bad_write_en", 32'(write_en), 32'd0);
    step();
    check("bad_err_pulse", 32'(cmd_err), 32'd0);
    check("bad_next_write_en", 32'(write_en), 32'h004);
    check("bad_next_datain", 32'(rf_datain), 32'h0C3);
    step();
    step();
    check("bad_write_count", 32'(wlog_en.size()), 32'd1);
    check("no_read_write_overlap", 32'(overlap), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/reg_transfer_ctrl.md
# reg_transfer_ctrl

Register-transfer sequencer that sits directly upstream of the processor's register file and drives it. It accepts move, load-immediate, increment and read-out commands through a valid/ready handshake and buffers them in a small FIFO. It executes each command as a one-hot read phase and/or a one-hot write phase on the register file's `read_en`/`write_en`/`datain` inputs, and returns read-out values on a result port.

## Interface
- `REG_COUNT`, 11: number of register-file entries (R, row, cAT, cB, rnow, cATnow, cBnow, alphap, betap, gammap, Total at indices 0..10).
- `REG_WIDTH`, 12: data width.
- `FIFO_DEPTH`, 4: command FIFO entries (power of two, ≥2).

One clock; reset is asynchronous and active-high.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  FIFO can accept a command; equals !full.
- `cmd_op`  in  2  00 MOV, 01 LDI, 10 INC, 11 RD.
- `cmd_src`  in  4  source register index (MOV, RD).
- `cmd_dst`  in  4  destination register index (MOV, LDI, INC).
- `cmd_imm`  in  REG_WIDTH  immediate (LDI).
- `read_en`  out  REG_COUNT  one-hot read select to register file.
- `write_en`  out  REG_COUNT  one-hot write select to register file.
- `rf_datain`  out  REG_WIDTH  write data to register file.
- `rf_dataout`  in  REG_WIDTH  combinational read data from register file.
- `result_valid`  out  1  one-cycle pulse, RD result present.
- `result_data`  out  REG_WIDTH  RD result, held until next RD completes.
- `cmd_err`  out  1  one-cycle pulse, command discarded for bad index.
- `busy`  out  1  FSM not IDLE or FIFO non-empty.

## Operation
- Push on rising edge with cmd_valid && cmd_ready. Stores {op, src, dst, imm}. No pop-bypass: when full, cmd_ready stays 0 even in the cycle a pop occurs.
- FSM states are IDLE, READ, WRITE, RESULT. Commands are popped in IDLE, WRITE or RESULT when the FIFO is non-empty. The popped command selects the next state:
  - MOV, INC, RD: go to READ.
  - LDI: go to WRITE with hold = imm.
  - Index ≥ REG_COUNT in any used field: discard the command, pulse cmd_err in the following cycle, return to IDLE.
- READ: read_en = one-hot(src); for INC, read_en = one-hot(dst). rf_dataout is captured into hold at the end of the cycle.
  - RD: write result_data = rf_dataout, then go to RESULT.
  - MOV, INC: go to WRITE.
- WRITE: write_en = one-hot(dst). rf_datain = hold for MOV/LDI, or hold+1 mod 2^REG_WIDTH for INC (0xFFF → 0x000).
- RESULT: result_valid = 1 for exactly one cycle.
- No pop pending in WRITE or RESULT: go to IDLE.
- Outside READ, read_en = 0. Outside WRITE, write_en = 0. Both are never non-zero in the same cycle.
- rf_datain = 0 outside WRITE.
- MOV with src == dst is legal and rewrites the same value.

## Timing
- Reset (asynchronous, immediate):
  - FIFO emptied; FSM to IDLE.
  - read_en = 0, write_en = 0, rf_datain = 0.
  - result_valid = 0, result_data = 0, cmd_err = 0, busy = 0, cmd_ready = 1.
  - A write in progress is aborted; write_en drops without waiting for a clock edge.
- All outputs are registered. cmd_ready derives from the registered count.
- Single MOV/INC into an idle block:
  - accept at edge 0, pop at edge 1.
  - read_en high in cycle 1–2, write_en high in cycle 2–3.
  - register file updates at edge 3.
- LDI: write_en high in the cycle after the pop edge.
- RD: result_valid high two cycles after the pop edge.
- Back-to-back throughput with a non-empty FIFO:
  - MOV/INC/RD: 2 cycles each.
  - LDI: 1 cycle each.
- cmd_err: one cycle after the pop edge of the offending command.

## Test plan
- Reset mid-WRITE of LDI dst=3 imm=0x5A5: write_en clears immediately on reset assertion. After release, cmd_ready=1, busy=0 and all outputs are 0.
- LDI dst=9 imm=0x123, then RD src=9: write_en=0x200 with rf_datain=0x123 for one cycle. Then read_en=0x200, and result_valid pulses with result_data=0x123.
- LDI dst=0 imm=0xFFF, INC dst=0, RD src=0: INC cycle drives read_en=0x001, then write_en=0x001 with rf_datain=0x000. RD returns 0x000.
- MOV src=4 dst=10 after LDI dst=4 imm=0x0AB: read_en=0x010 then write_en=0x400 with rf_datain=0x0AB. RD src=10 returns 0x0AB.
- Hold cmd_valid=1 with 6 LDI commands while execution is stalled by preceding RDs: cmd_ready drops after the 4th accept. No command is lost or duplicated, and all 6 writes appear in order.
- MOV src=11 dst=2: no read_en/write_en activity, cmd_err pulses once, and the next queued command executes normally.
